// File: rtl/nivel_hambre_pkg.sv
// Shared types and constants for the hunger-level block: debounce FSM states,
// level limits and saturating level helpers.
package nivel_hambre_pkg;

    typedef enum logic [1:0] {
        StSuelto          = 2'd0,
        StConfirmaPresion = 2'd1,
        StPresionado      = 2'd2,
        StConfirmaSuelta  = 2'd3
    } antirrebote_st_e;

    typedef logic [1:0] nivel_t;

    localparam nivel_t NIVEL_MAX = 2'd3;
    localparam nivel_t NIVEL_MIN = 2'd0;

    function automatic nivel_t nivel_sube(input nivel_t nivel);
        return (nivel == NIVEL_MAX) ? NIVEL_MAX : nivel_t'(nivel + 2'd1);
    endfunction

    function automatic nivel_t nivel_baja(input nivel_t nivel);
        return (nivel == NIVEL_MIN) ? NIVEL_MIN : nivel_t'(nivel - 2'd1);
    endfunction

endpackage

// File: rtl/nivel_hambre_antirrebote.sv
// Two-flop synchronizer plus debounce FSM for the food button. Reports the
// debounced level and a one-cycle (combinational) pulse on each accepted press.
module antirrebote
    import nivel_hambre_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic boton_i,
    output logic estable_o,
    output logic pulso_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that enters a confirm state is the first stable one, so the
    // last needed sample arrives when the counter holds DEBOUNCE_CYCLES-1.
    localparam logic [CntW-1:0] CntFin = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    antirrebote_st_e estado_q;
    antirrebote_st_e estado_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            estado_q <= StSuelto;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= boton_i;
            sync2_q  <= sync1_q;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pulso_o  = 1'b0;
        unique case (estado_q)
            StSuelto: begin
                if (sync2_q) begin
                    estado_d = StConfirmaPresion;
                    cnt_d    = '0;
                end
            end
            StConfirmaPresion: begin
                if (!sync2_q) begin
                    estado_d = StSuelto;
                end else if (cnt_q == CntFin) begin
                    estado_d = StPresionado;
                    pulso_o  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPresionado: begin
                if (!sync2_q) begin
                    estado_d = StConfirmaSuelta;
                    cnt_d    = '0;
                end
            end
            StConfirmaSuelta: begin
                if (sync2_q) begin
                    estado_d = StPresionado;
                end else if (cnt_q == CntFin) begin
                    estado_d = StSuelto;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    assign estable_o = (estado_q == StPresionado) || (estado_q == StConfirmaSuelta);

endmodule

// File: rtl/nivel_hambre.sv
// Hunger level tracker: debounced food presses raise the level, a free-running
// decay counter lowers it; Hambriento flags the empty level.
module nivel_hambre
    import nivel_hambre_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DECAY_CYCLES    = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Boton_Comida,
    output logic [1:0] Nivel,
    output logic       Comida_Pulso,
    output logic       Hambriento
);

    localparam int unsigned DecW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [DecW-1:0] DecFin = DecW'(DECAY_CYCLES - 1);

    logic            acepta;
    logic            boton_estable;
    nivel_t          nivel_q;
    nivel_t          nivel_d;
    logic [DecW-1:0] decay_q;
    logic [DecW-1:0] decay_d;
    logic            pulso_q;
    logic            hambre_q;

    antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
        .clk_i    (clk),
        .rst_ni   (reset),
        .boton_i  (Boton_Comida),
        .estable_o(boton_estable),
        .pulso_o  (acepta)
    );

    // A press outranks a simultaneous decay wrap and restarts the decay period.
    always_comb begin
        nivel_d = nivel_q;
        decay_d = decay_q;
        if (acepta) begin
            nivel_d = nivel_sube(nivel_q);
            decay_d = '0;
        end else if (decay_q == DecFin) begin
            nivel_d = nivel_baja(nivel_q);
            decay_d = '0;
        end else begin
            decay_d = decay_q + DecW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nivel_q  <= NIVEL_MAX;
            decay_q  <= '0;
            pulso_q  <= 1'b0;
            hambre_q <= 1'b0;
        end else begin
            nivel_q  <= nivel_d;
            decay_q  <= decay_d;
            pulso_q  <= acepta;
            hambre_q <= (nivel_d == NIVEL_MIN);
        end
    end

    // Presses can only be accepted from the released side of the debouncer.
    pulso_desde_suelto_a: assert property (
        @(posedge clk) disable iff (!reset) acepta |-> !boton_estable
    );

    assign Nivel        = nivel_q;
    assign Comida_Pulso = pulso_q;
    assign Hambriento   = hambre_q;

endmodule

// File: tb/tb_nivel_hambre.sv
// Bench for nivel_hambre: directed scenarios plus random button/reset traffic,
// all checked every cycle against a run-length behavioural model.
module tb_nivel_hambre;

    localparam int DEB = 4;
    localparam int DEC = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Boton_Comida = 1'b0;
    logic [1:0] Nivel;
    logic       Comida_Pulso;
    logic       Hambriento;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_hist[2];
    int m_estable, m_run, m_nivel, m_decay, m_pulso, m_hambre;
    int cyc;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;

    nivel_hambre #(
        .DEBOUNCE_CYCLES(DEB),
        .DECAY_CYCLES   (DEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Boton_Comida(Boton_Comida),
        .Nivel       (Nivel),
        .Comida_Pulso(Comida_Pulso),
        .Hambriento  (Hambriento)
    );

    always #5 clk = ~clk;

    // Press accepted after DEB+1 consecutive synchronized samples that differ
    // from the accepted level; level/decay follow the arithmetic rules.
    always @(posedge clk) begin
        int synced;
        int acc;
        if (!reset) begin
            m_hist[0] = 0; m_hist[1] = 0;
            m_estable = 0; m_run = 0; m_nivel = 3; m_decay = 0;
            m_pulso = 0; m_hambre = 0; cyc = 0;
        end else begin
            cyc++;
            synced = m_hist[1];
            acc = 0;
            if (synced != m_estable) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_estable = synced;
                    m_run = 0;
                    acc = synced;
                end
            end else begin
                m_run = 0;
            end
            m_hist[1] = m_hist[0];
            m_hist[0] = int'(Boton_Comida);
            if (acc != 0) begin
                m_nivel = (m_nivel < 3) ? m_nivel + 1 : 3;
                m_decay = 0;
            end else if (m_decay == DEC - 1) begin
                m_decay = 0;
                m_nivel = (m_nivel > 0) ? m_nivel - 1 : 0;
            end else begin
                m_decay++;
            end
            m_pulso = acc;
            m_hambre = (m_nivel == 0) ? 1 : 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_eq("nivel", 32'(Nivel), 32'(m_nivel));
        check_eq("pulso", 32'(Comida_Pulso), 32'(m_pulso));
        check_eq("hambriento", 32'(Hambriento), 32'(m_hambre));
        if (Comida_Pulso === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    initial begin
        int p0;
        int c0;

        // Reset for 4 cycles
        repeat (4) tick();
        check_eq("rst_nivel", 32'(Nivel), 32'd3);
        check_eq("rst_hambre", 32'(Hambriento), 32'd0);
        check_eq("rst_pulso", 32'(Comida_Pulso), 32'd0);
        reset = 1'b1;

        // Idle decay 3->2->1->0 at cycles 50/100/150, holding 0 through 200
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (cyc == 49)  check_eq("decay49", 32'(Nivel), 32'd3);
            if (cyc == 50)  check_eq("decay50", 32'(Nivel), 32'd2);
            if (cyc == 100) check_eq("decay100", 32'(Nivel), 32'd1);
            if (cyc == 149) check_eq("hambre149", 32'(Hambriento), 32'd0);
            if (cyc == 150) begin
                check_eq("decay150", 32'(Nivel), 32'd0);
                check_eq("hambre150", 32'(Hambriento), 32'd1);
            end
            if (cyc == 200) check_eq("decay200", 32'(Nivel), 32'd0);
        end

        // Bounce: toggling every 2 cycles never debounces
        p0 = pulse_cnt;
        for (int i = 0; i < 30; i++) begin
            Boton_Comida = ((i / 2) % 2) != 0;
            tick();
        end
        Boton_Comida = 1'b0;
        repeat (6) tick();
        check_eq("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);
        check_eq("bounce_nivel", 32'(Nivel), 32'd0);

        // Clean 20-cycle press from level 0
        p0 = pulse_cnt;
        c0 = cyc;
        Boton_Comida = 1'b1;
        repeat (20) tick();
        Boton_Comida = 1'b0;
        check_eq("press_pulses", 32'(pulse_cnt - p0), 32'd1);
        check_eq("press_latency", 32'(last_pulse_cyc - c0), 32'd7);
        check_eq("press_nivel", 32'(Nivel), 32'd1);
        // Decay restarted on the accept edge: next drop exactly DEC cycles later
        while (cyc < c0 + 7 + DEC - 1) tick();
        check_eq("restart_hold", 32'(Nivel), 32'd1);
        tick();
        check_eq("restart_drop", 32'(Nivel), 32'd0);

        // Reset in CONFIRMA_PRESION with the button let go during reset
        do_reset(2);
        Boton_Comida = 1'b1;
        repeat (4) tick();
        Boton_Comida = 1'b0;
        p0 = pulse_cnt;
        do_reset(3);
        repeat (20) tick();
        check_eq("abort_pulses", 32'(pulse_cnt - p0), 32'd0);
        check_eq("abort_nivel", 32'(Nivel), 32'd3);

        // Button held through reset release counts as one new press
        Boton_Comida = 1'b1;
        p0 = pulse_cnt;
        do_reset(3);
        repeat (20) tick();
        check_eq("held_pulses", 32'(pulse_cnt - p0), 32'd1);
        check_eq("held_nivel", 32'(Nivel), 32'd3);
        Boton_Comida = 1'b0;
        repeat (12) tick();

        // Accept lands on decay wrap at level 2: press wins
        do_reset(2);
        repeat (93) tick();
        Boton_Comida = 1'b1;
        repeat (6) tick();
        check_eq("coll_pre", 32'(Nivel), 32'd2);
        tick();
        check_eq("coll_cyc", 32'(cyc), 32'd100);
        check_eq("coll_nivel", 32'(Nivel), 32'd3);
        check_eq("coll_pulso", 32'(Comida_Pulso), 32'd1);
        repeat (15) tick();
        Boton_Comida = 1'b0;
        repeat (60) tick();

        // Random button stretches with occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 3) begin
                Boton_Comida = 1'($urandom_range(0, 1));
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                Boton_Comida = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 14)) tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
